// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: collects ALU and MUL/DIV results into one registered
// writeback port. ALU results pass through a small FIFO that absorbs
// writeback backpressure. MUL/DIV results are handed straight to the output
// register when granted. Two-way round-robin arbitration.
module fu_wb_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int ROB_IDX_WIDTH  = 7,
  parameter int ALU_FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [PREG_IDX_WIDTH-1:0] alu_prd,
  input  logic [ROB_IDX_WIDTH-1:0]  alu_robid,
  input  logic                      alu_need_wb,
  input  logic                      md_valid,
  output logic                      md_ready,
  input  logic [DATA_WIDTH-1:0]     md_result,
  input  logic [PREG_IDX_WIDTH-1:0] md_prd,
  input  logic [ROB_IDX_WIDTH-1:0]  md_robid,
  input  logic                      md_need_wb,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [DATA_WIDTH-1:0]     wb_result,
  output logic [PREG_IDX_WIDTH-1:0] wb_prd,
  output logic [ROB_IDX_WIDTH-1:0]  wb_robid,
  output logic                      wb_need_wb,
  output logic                      wb_src
);

  localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ALU_FIFO_DEPTH);

  // Source encoding shared by last_grant and wb_src.
  localparam logic [0:0] SRC_ALU = 1'b0;
  localparam logic [0:0] SRC_MD  = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic [PREG_IDX_WIDTH-1:0] prd;
    logic [ROB_IDX_WIDTH-1:0]  robid;
    logic                      need_wb;
  } entry_t;

  entry_t             fifo_mem [ALU_FIFO_DEPTH];
  entry_t             alu_entry;
  entry_t             head_entry;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [0:0]         last_grant_reg;
  logic               wb_valid_reg;
  entry_t             wb_entry_reg;
  logic               wb_src_reg;

  logic push;
  logic load_en;
  logic cand_alu;
  logic cand_md;
  logic grant_alu;
  logic grant_md;

  assign alu_entry  = '{result: alu_result, prd: alu_prd, robid: alu_robid, need_wb: alu_need_wb};
  assign head_entry = fifo_mem[rd_ptr_reg];

  // Full-FIFO stall ignores a same-cycle pop so alu_ready stays register-timed.
  assign alu_ready = (count_reg < DEPTH_CNT) && !flush;
  assign push      = alu_valid && alu_ready;
  assign load_en   = (!wb_valid_reg || wb_ready) && !flush;
  assign cand_alu  = (count_reg != '0);
  assign cand_md   = md_valid;

  // Round-robin: on contention the source that did not win last time goes.
  always_comb begin
    grant_alu = 1'b0;
    grant_md  = 1'b0;
    if (load_en) begin
      if (cand_alu && cand_md) begin
        grant_alu = (last_grant_reg == SRC_MD);
        grant_md  = (last_grant_reg == SRC_ALU);
      end else begin
        grant_alu = cand_alu;
        grant_md  = cand_md;
      end
    end
  end

  assign md_ready = grant_md;

  // Occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, grant_alu})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Per-entry payload storage; contents of empty slots are never read.
  generate
    for (genvar gi = 0; gi < ALU_FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clock) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_mem[gi] <= alu_entry;
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (grant_alu) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Writeback output register and arbitration history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_reg   <= 1'b0;
      wb_entry_reg   <= '0;
      wb_src_reg     <= 1'b0;
      last_grant_reg <= SRC_MD;
    end else if (flush) begin
      wb_valid_reg <= 1'b0;
    end else if (grant_alu) begin
      wb_valid_reg   <= 1'b1;
      wb_entry_reg   <= head_entry;
      wb_src_reg     <= SRC_ALU;
      last_grant_reg <= SRC_ALU;
    end else if (grant_md) begin
      wb_valid_reg   <= 1'b1;
      wb_entry_reg   <= '{result: md_result, prd: md_prd, robid: md_robid, need_wb: md_need_wb};
      wb_src_reg     <= SRC_MD;
      last_grant_reg <= SRC_MD;
    end else if (load_en) begin
      wb_valid_reg <= 1'b0;
    end
  end

  assign wb_valid   = wb_valid_reg;
  assign wb_result  = wb_entry_reg.result;
  assign wb_prd     = wb_entry_reg.prd;
  assign wb_robid   = wb_entry_reg.robid;
  assign wb_need_wb = wb_entry_reg.need_wb;
  assign wb_src     = wb_src_reg;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: expected writebacks are queued as the
// stimulus is driven and compared when the DUT completes a wb transfer.
module tb_fu_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [63:0] alu_result;
  logic [5:0]  alu_prd;
  logic [6:0]  alu_robid;
  logic        alu_need_wb;
  logic        md_valid;
  logic        md_ready;
  logic [63:0] md_result;
  logic [5:0]  md_prd;
  logic [6:0]  md_robid;
  logic        md_need_wb;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_result;
  logic [5:0]  wb_prd;
  logic [6:0]  wb_robid;
  logic        wb_need_wb;
  logic        wb_src;

  typedef struct packed {
    logic        src;
    logic        need_wb;
    logic [6:0]  robid;
    logic [5:0]  prd;
    logic [63:0] result;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks;
  int  n_fail;
  int  md_ready_cnt;
  logic alu_acc;
  logic md_acc;

  fu_wb_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_result  (alu_result),
    .alu_prd     (alu_prd),
    .alu_robid   (alu_robid),
    .alu_need_wb (alu_need_wb),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_result   (md_result),
    .md_prd      (md_prd),
    .md_robid    (md_robid),
    .md_need_wb  (md_need_wb),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_result   (wb_result),
    .wb_prd      (wb_prd),
    .wb_robid    (wb_robid),
    .wb_need_wb  (wb_need_wb),
    .wb_src      (wb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input wb_t obs, input wb_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed src=%0b nwb=%0b robid=%0h prd=%0h res=%0h expected src=%0b nwb=%0b robid=%0h prd=%0h res=%0h",
             tag, obs.src, obs.need_wb, obs.robid, obs.prd, obs.result,
             exp.src, exp.need_wb, exp.robid, exp.prd, exp.result);
    end
  endtask

  task automatic expect_wb(input logic src, input logic nwb, input logic [6:0] rb,
                           input logic [5:0] p, input logic [63:0] r);
    wb_t e;
    e = '{src: src, need_wb: nwb, robid: rb, prd: p, result: r};
    exp_q.push_back(e);
  endtask

  task automatic drive_alu(input logic [63:0] r, input logic [5:0] p,
                           input logic [6:0] rb, input logic nwb);
    alu_valid   = 1'b1;
    alu_result  = r;
    alu_prd     = p;
    alu_robid   = rb;
    alu_need_wb = nwb;
  endtask

  task automatic drive_md(input logic [63:0] r, input logic [5:0] p,
                          input logic [6:0] rb, input logic nwb);
    md_valid   = 1'b1;
    md_result  = r;
    md_prd     = p;
    md_robid   = rb;
    md_need_wb = nwb;
  endtask

  // One clock cycle: sample handshakes mid-cycle, score any wb transfer,
  // then advance past the edge and retire accepted source requests.
  task automatic tick();
    wb_t obs;
    wb_t e;
    #1;
    alu_acc = alu_valid && alu_ready;
    md_acc  = md_valid && md_ready;
    if (md_ready) md_ready_cnt++;
    if (wb_valid && wb_ready) begin
      obs = '{src: wb_src, need_wb: wb_need_wb, robid: wb_robid, prd: wb_prd, result: wb_result};
      check_int("wb_expected_present", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_wb("wb_payload", obs, e);
        $display("wb transfer: src=%0b robid=%0h prd=%0h result=%0h", obs.src, obs.robid, obs.prd, obs.result);
      end else begin
        $display("wb transfer with no expectation: robid=%0h result=%0h", obs.robid, obs.result);
      end
    end
    @(posedge clock);
    #1;
    if (alu_acc) alu_valid = 1'b0;
    if (md_acc)  md_valid  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb_valid || alu_valid || md_valid) && n < 40) begin
      tick();
      n++;
    end
    check_int(tag, exp_q.size(), 0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    md_ready_cnt = 0;
    alu_acc      = 1'b0;
    md_acc       = 1'b0;
    reset_n      = 1'b0;
    flush        = 1'b0;
    alu_valid    = 1'b0;
    alu_result   = 64'h0;
    alu_prd      = 6'd0;
    alu_robid    = 7'd0;
    alu_need_wb  = 1'b0;
    md_valid     = 1'b0;
    md_result    = 64'h0;
    md_prd       = 6'd0;
    md_robid     = 7'd0;
    md_need_wb   = 1'b0;
    wb_ready     = 1'b1;

    // Reset state
    #2;
    check_bit("rst_wb_valid", wb_valid, 1'b0);
    check_bit("rst_alu_ready", alu_ready, 1'b1);
    check_bit("rst_md_ready", md_ready, 1'b0);
    check_wb("rst_wb_payload", {wb_src, wb_need_wb, wb_robid, wb_prd, wb_result}, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single ALU result: two-cycle latency, then wb_valid clears
    drive_alu(64'h1234, 6'd5, 7'd3, 1'b1);
    expect_wb(1'b0, 1'b1, 7'd3, 6'd5, 64'h1234);
    tick();
    check_bit("alu_accept", alu_acc, 1'b1);
    check_bit("alu_lat_not_yet", wb_valid, 1'b0);
    tick();
    check_bit("alu_lat2_valid", wb_valid, 1'b1);
    tick();
    check_bit("alu_wb_clears", wb_valid, 1'b0);
    check_int("alu_single_q", exp_q.size(), 0);

    // MUL/DIV single-cycle latency, then hold under backpressure
    wb_ready = 1'b0;
    drive_md(64'h77, 6'd9, 7'h11, 1'b1);
    expect_wb(1'b1, 1'b1, 7'h11, 6'd9, 64'h77);
    #1;
    check_bit("md_ready_empty_wb", md_ready, 1'b1);
    tick();
    check_bit("md_lat1_valid", wb_valid, 1'b1);
    check_bit("md_lat1_src", wb_src, 1'b1);

    // Round robin: FIFO gets A and B while wb is stalled on the MD result
    drive_alu(64'hA, 6'd1, 7'h0A, 1'b1);
    tick();
    drive_alu(64'hB, 6'd2, 7'h0B, 1'b0);
    tick();
    check_bit("hold_valid", wb_valid, 1'b1);
    check_bit("hold_result", (wb_result == 64'h77), 1'b1);
    md_ready_cnt = 0;
    drive_md(64'hD, 6'd4, 7'h0D, 1'b1);
    expect_wb(1'b0, 1'b1, 7'h0A, 6'd1, 64'hA);
    expect_wb(1'b1, 1'b1, 7'h0D, 6'd4, 64'hD);
    expect_wb(1'b0, 1'b0, 7'h0B, 6'd2, 64'hB);
    wb_ready = 1'b1;
    drain("rr_drain");
    check_int("rr_md_ready_cycles", md_ready_cnt, 1);

    // Backpressure and full FIFO
    wb_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      drive_alu(64'(v), 6'(v), 7'(v), 1'b1);
      expect_wb(1'b0, 1'b1, 7'(v), 6'(v), 64'(v));
      tick();
      check_bit("full_push_accept", alu_acc, 1'b1);
    end
    drive_alu(64'd6, 6'd6, 7'd6, 1'b1);
    expect_wb(1'b0, 1'b1, 7'd6, 6'd6, 64'd6);
    #1;
    check_bit("full_alu_ready_low", alu_ready, 1'b0);
    check_bit("full_wb_valid", wb_valid, 1'b1);
    tick();
    tick();
    check_bit("full_push_blocked", alu_acc, 1'b0);
    check_bit("full_wb_holds_1", (wb_result == 64'd1), 1'b1);
    wb_ready = 1'b1;
    #1;
    check_bit("full_ready_low_on_pop", alu_ready, 1'b0);
    drain("full_drain");

    // Simultaneous push and pop: steady stream, one writeback per cycle
    for (int i = 0; i < 8; i++) begin
      drive_alu(64'(32'h100 + i), 6'(i + 10), 7'(i + 32), i[0]);
      expect_wb(1'b0, i[0], 7'(i + 32), 6'(i + 10), 64'(32'h100 + i));
      tick();
      check_bit("stream_accept", alu_acc, 1'b1);
      if (i >= 1) check_bit("stream_wb_valid", wb_valid, 1'b1);
    end
    drain("stream_drain");

    // Flush: three buffered entries plus a valid wb entry, all discarded
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_alu(64'(32'h300 + i), 6'(i), 7'(i + 48), 1'b1);
      tick();
    end
    check_bit("flush_pre_valid", wb_valid, 1'b1);
    flush = 1'b1;
    drive_md(64'h55, 6'd7, 7'h55, 1'b1);
    drive_alu(64'h399, 6'd9, 7'h59, 1'b1);
    #1;
    check_bit("flush_md_ready", md_ready, 1'b0);
    check_bit("flush_alu_ready", alu_ready, 1'b0);
    tick();
    flush     = 1'b0;
    md_valid  = 1'b0;
    alu_valid = 1'b0;
    #1;
    check_bit("flush_wb_cleared", wb_valid, 1'b0);
    check_bit("flush_alu_ready_back", alu_ready, 1'b1);
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_bit("flush_no_resurrect", wb_valid, 1'b0);

    // Async reset mid-stream, then first contested grant goes to ALU
    wb_ready = 1'b0;
    drive_alu(64'h400, 6'd3, 7'h40, 1'b1);
    tick();
    tick();
    check_bit("areset_pre_valid", wb_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("areset_wb_valid", wb_valid, 1'b0);
    check_bit("areset_alu_ready", alu_ready, 1'b1);
    check_bit("areset_wb_result_zero", (wb_result == 64'h0), 1'b1);
    #1;
    reset_n  = 1'b1;
    wb_ready = 1'b1;
    tick();
    drive_alu(64'h501, 6'd11, 7'h51, 1'b1);
    expect_wb(1'b0, 1'b1, 7'h51, 6'd11, 64'h501);
    expect_wb(1'b1, 1'b0, 7'h52, 6'd12, 64'h502);
    tick();
    drive_md(64'h502, 6'd12, 7'h52, 1'b0);
    #1;
    check_bit("areset_contest_md_waits", md_ready, 1'b0);
    drain("areset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
